// File: rtl/vote_machine_n.sv
// vote_machine_n: N-candidate voting machine with debounced buttons,
// saturating tallies, leader/tie tracking and a voting/result LED bank.
module vote_machine_n #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 10,
  parameter int ACK_CYCLES  = 10,
  localparam int IDX_W =
    (NUM_CAND > 2) ? $clog2(NUM_CAND) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic [NUM_CAND-1:0] button,
  output logic [CNT_W-1:0]    led,
  output logic [IDX_W-1:0]    winner,
  output logic                winner_valid,
  output logic                tie,
  output logic                rejected,
  output logic                saturated
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int AW = $clog2(ACK_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ARM = HW'(HOLD_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_CYCLES);
  localparam logic [CNT_W-1:0] TALLY_MAX = '1;

  logic [HW-1:0]    hold_cnt [NUM_CAND];
  logic [NUM_CAND-1:0] press;

  logic [CNT_W-1:0] tally   [NUM_CAND];
  logic [CNT_W-1:0] tally_d [NUM_CAND];
  logic [IDX_W-1:0] sel, sel_d;
  logic [AW-1:0]    ack, ack_d;
  logic [CNT_W-1:0] led_d;
  logic             sat_d, rej_d;

  logic             press_any, press_multi, press_one;
  logic [IDX_W-1:0] press_idx;

  logic [CNT_W-1:0] max_v;
  logic [IDX_W-1:0] best;
  logic             tie_d;

  // Per-button hold counter; one press pulse per qualified hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CAND; i++) hold_cnt[i] <= '0;
      press <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) begin
        if (!button[i]) begin
          hold_cnt[i] <= '0;
          press[i]    <= 1'b0;
        end else begin
          if (hold_cnt[i] != HOLD_MAX)
            hold_cnt[i] <= hold_cnt[i] + HW'(1);
          press[i] <= (hold_cnt[i] == HOLD_ARM);
        end
      end
    end
  end

  // Classify the press vector: none, exactly one, or several
  always_comb begin
    press_idx   = '0;
    press_any   = |press;
    press_multi =
      (press & (press - NUM_CAND'(1))) != '0;
    press_one   = press_any & ~press_multi;
    for (int i = 0; i < NUM_CAND; i++)
      if (press[i]) press_idx = IDX_W'(i);
  end

  // Ballot handling, selection, ack timer and LED next values
  always_comb begin
    tally_d = tally;
    sel_d   = sel;
    ack_d   = ack;
    sat_d   = saturated;
    rej_d   = 1'b0;
    if (mode) begin
      ack_d = '0;
      if (press_one) sel_d = press_idx;
    end else begin
      if (ack != '0) ack_d = ack - AW'(1);
      if (press_one) begin
        if (tally[press_idx] == TALLY_MAX)
          sat_d = 1'b1;
        else
          tally_d[press_idx] =
            tally[press_idx] + CNT_W'(1);
        ack_d = ACK_LOAD;
      end else if (press_multi) begin
        rej_d = 1'b1;
      end
    end
    if (mode)
      led_d = tally_d[sel_d];
    else
      led_d = (ack_d != '0) ? '1 : '0;
  end

  // Leader search; strict compare keeps the lowest index on ties
  always_comb begin
    max_v = tally[0];
    best  = '0;
    tie_d = 1'b0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (tally[i] > max_v) begin
        max_v = tally[i];
        best  = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++)
      if (IDX_W'(i) != best && tally[i] == max_v
          && max_v != '0)
        tie_d = 1'b1;
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
      sel          <= '0;
      ack          <= '0;
      led          <= '0;
      saturated    <= 1'b0;
      rejected     <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      tie          <= 1'b0;
    end else begin
      tally        <= tally_d;
      sel          <= sel_d;
      ack          <= ack_d;
      led          <= led_d;
      saturated    <= sat_d;
      rejected     <= rej_d;
      winner       <= best;
      winner_valid <= (max_v != '0);
      tie          <= tie_d;
    end
  end

endmodule

// File: doc/vote_machine_n.md
# vote_machine_n

Parametrised N-candidate electronic voting machine and the successor to the team's fixed four-candidate top level. It debounces each candidate button and rejects any ballot where more than one candidate registers in the same cycle. It keeps saturating per-candidate tallies, continuously tracks the leader and ties, and drives the LED bank in voting or result mode. It sits directly under the board wrapper, with `button` fed from board push-buttons already synchronised to `clock`.

## Interface
- `NUM_CAND`, 4: number of candidates, 2..16.
- `CNT_W`, 8: tally width and LED width.
- `HOLD_CYCLES`, 10: consecutive high samples required to register a press, ≥2.
- `ACK_CYCLES`, 10: length of the voting-mode acknowledge flash, ≥1.
- `IDX_W` (derived, not overridable): max(1, clog2(NUM_CAND)).

- `clock`  in  1: single clock; all state is updated on its rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state.
- `mode`  in  1: 0 = voting, 1 = result display.
- `button`  in  NUM_CAND: candidate buttons, active-high.
- `led`  out  CNT_W: LED bank.
- `winner`  out  IDX_W: index of the leading candidate.
- `winner_valid`  out  1: high when at least one tally is nonzero.
- `tie`  out  1: high when two or more candidates share the nonzero maximum.
- `rejected`  out  1: one-cycle pulse when a multi-press ballot is discarded.
- `saturated`  out  1: sticky; set when any tally would exceed 2^CNT_W−1.

## Operation
- **Reset values:** every output register resets to 0, as do all tallies, hold counters, the ack timer and `sel` (the result-mode selection).
- **Press qualifier, per button:**
  - `hold_cnt[i]` increments while `button[i]` is high and clears whenever it is low.
  - `press[i]` is a registered one-cycle pulse, asserted on the edge where `hold_cnt[i]` goes from HOLD_CYCLES−1 to HOLD_CYCLES.
  - The counter then holds at HOLD_CYCLES, so a held button gives exactly one pulse; the button must be released to re-arm.
- **Voting mode (`mode`=0):**
  - Exactly one `press` bit high: that tally increments and the ack timer loads ACK_CYCLES.
  - Two or more bits high in the same cycle: no tally changes, `rejected` pulses, and the ack timer is unchanged.
  - A tally at 2^CNT_W−1 stays there; `saturated` sets and the ack timer still loads.
  - `led` is all ones while the ack timer is nonzero, otherwise 0. The timer decrements to 0.
- **Result mode (`mode`=1):**
  - Tallies are frozen.
  - A single `press[i]` sets `sel`=i. A multi-press leaves `sel` unchanged and does not pulse `rejected`.
  - `led` = tally[sel].
- **Mode changes:**
  - Entering result mode clears the ack timer.
  - Tallies and `sel` persist across mode changes.
  - `hold_cnt` runs regardless of mode, so a press qualified in the cycle `mode` changes is interpreted under the new `mode` value as sampled.
- **Leader tracker (registered):**
  - `winner` is the index of the maximum tally; the lowest index wins ties.
  - `tie` is high when another index has an equal, nonzero tally.
  - `winner_valid` = OR of nonzero tallies.
  - With all tallies 0: `winner`=0, `tie`=0.
- `saturated` clears only on reset.

## Timing
- **Press latency:** with `button[i]` first sampled high at edge 1 and held, `press[i]` is high after edge HOLD_CYCLES for one cycle.
- **Tally/ack latency:** the tally and ack timer update at edge HOLD_CYCLES+1. `led` goes all-ones after that edge and stays for ACK_CYCLES cycles.
- **Tracker latency:** `winner`, `tie` and `winner_valid` reflect new tallies one edge later, at HOLD_CYCLES+2.
- **Rejection:** `rejected` is a registered pulse asserted in the same cycle the tally would otherwise have updated.
- **Result-mode LED:** `led` is registered and reflects a new `sel` or mode one edge after the triggering event.
- **Release before qualifying:** releasing a button before HOLD_CYCLES samples clears its counter, so no pulse and no count.
- **Reset mid-operation:** reset asserted at any time takes effect immediately and asynchronously. A press in progress is discarded.
- **Re-press during ack flash:** a new single vote reloads the ack timer to ACK_CYCLES.

## Test plan
- **Basic vote and flash:** reset, `mode`=0, HOLD=10, ACK=10, hold `button[2]` for 15 cycles → tally[2]=1 at edge 11; `led`=8'hFF for exactly 10 cycles; `winner`=2 and `winner_valid`=1 at edge 12; only one count although the button stays held.
- **Debounce reject:** `button[1]` high for 9 cycles, then low → no tally change, `led` stays 0.
- **Multi-press reject:** `button[0]` and `button[3]` rise on the same edge and are held 12 cycles → `rejected` pulses once at edge 11; all tallies 0; `led` stays 0.
- **Result mode and ties:** cast 3 votes for candidate 1 and 3 for candidate 3, then `mode`=1 and press `button[3]` → `led`=3, `winner`=1, `tie`=1. A further vote attempt in result mode leaves tallies unchanged.
- **Saturation:** CNT_W=2, cast 5 votes for candidate 0 → tally[0]=3, `saturated`=1 after the 4th vote, and the ack flash still occurs on the 4th and 5th votes.
- **Reset mid-flash:** assert `reset` low during the ack flash → `led`, tallies, `winner`, `tie` and `saturated` read 0 immediately, without waiting for a clock edge.
